// File: rtl/sar_scan_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_scan_sequencer_pkg: shared types and helpers for the SAR scanner  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package sar_scan_sequencer_pkg;

   localparam int MAX_CH      = 16;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_CONVERT = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } nsb_t;

   // Lowest set bit of mask at or above index 'from'.
   function automatic nsb_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                         input logic [4:0] from);
      nsb_t r;
      r = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (mask[i] && (5'(i) >= from)) begin
            r.found = 1'b1;
            r.idx   = 4'(i);
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sar_scan_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_scan_sequencer_if: mux select and go/valid link to SAR controller |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface sar_scan_sequencer_if #(
   parameter int NCH = 4,
   parameter int W   = 8
);
   logic [$clog2(NCH)-1:0] ch_sel;
   logic                   conv_go;
   logic                   conv_valid;
   logic [W-1:0]           conv_result;

   modport master (output ch_sel, output conv_go, input conv_valid, input conv_result);
   modport slave  (input ch_sel, input conv_go, output conv_valid, output conv_result);
endinterface
`default_nettype wire

// File: rtl/sar_scan_sequencer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_result_bank: per-channel result registers, sync write, comb read  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sar_result_bank #(
   parameter int NCH = 4,
   parameter int W   = 8
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   input  wire logic                   we,
   input  wire logic [$clog2(NCH)-1:0] waddr,
   input  wire logic [W-1:0]           wdata,
   input  wire logic [$clog2(NCH)-1:0] raddr,
   output logic      [W-1:0]           rdata
);
   logic [W-1:0] r_mem [NCH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) r_mem[i] <= '0;
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Unpopulated addresses exist when NCH is not a power of two.
   assign rdata = (32'(raddr) < NCH) ? r_mem[raddr] : '0;
endmodule
`default_nettype wire

// File: rtl/sar_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sar_scan_sequencer: multi-channel scan scheduler for the SAR datapath |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sar_scan_sequencer
   import sar_scan_sequencer_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int W        = 8,
   parameter int SETTLE_W = 4,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   input  wire logic                   start,
   input  wire logic                   continuous,
   input  wire logic                   stop,
   input  wire logic [NCH-1:0]         ch_en,
   input  wire logic [SETTLE_W-1:0]    settle,
   sar_scan_sequencer_if.master        conv,
   input  wire logic [$clog2(NCH)-1:0] rd_addr,
   output logic      [W-1:0]           rd_data,
   output logic                        data_valid,
   output logic      [$clog2(NCH)-1:0] data_ch,
   output logic      [W-1:0]           data,
   output logic                        busy,
   output logic                        scan_done,
   output logic                        err
);
   localparam int c_cw  = $clog2(NCH);
   localparam int c_wdw = $clog2(TIMEOUT + 1);

   state_t              r_state;
   logic [NCH-1:0]      r_mask;
   logic [c_cw-1:0]     r_ch_sel;
   logic [SETTLE_W-1:0] r_cnt;
   logic [c_wdw-1:0]    r_wdog;
   logic                r_go, r_busy, r_stop, r_dv, r_sd, r_err;
   logic [c_cw-1:0]     r_dch;
   logic [W-1:0]        r_data;

   nsb_t w_first, w_next;
   logic w_we, w_stop_req;

   assign w_first    = next_set_bit(MAX_CH'(ch_en), 5'd0);
   assign w_next     = next_set_bit(MAX_CH'(r_mask), 5'(r_ch_sel) + 5'd1);
   assign w_we       = (r_state == S_CONVERT) && conv.conv_valid;
   assign w_stop_req = r_stop | stop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_mask   <= '0;
         r_ch_sel <= '0;
         r_cnt    <= '0;
         r_wdog   <= '0;
         r_go     <= 1'b0;
         r_busy   <= 1'b0;
         r_stop   <= 1'b0;
         r_dv     <= 1'b0;
         r_sd     <= 1'b0;
         r_err    <= 1'b0;
         r_dch    <= '0;
         r_data   <= '0;
      end else begin
         r_dv <= 1'b0;
         r_sd <= 1'b0;
         if (r_busy && stop) r_stop <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_err <= 1'b0;
                  if (w_first.found) begin
                     r_mask   <= ch_en;
                     r_ch_sel <= c_cw'(w_first.idx);
                     r_cnt    <= settle;
                     r_busy   <= 1'b1;
                     r_state  <= S_SETTLE;
                  end else begin
                     r_sd <= 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_go    <= 1'b1;
                  r_wdog  <= '0;
                  r_state <= S_CONVERT;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_CONVERT: begin
               if (conv.conv_valid) begin
                  r_dv    <= 1'b1;
                  r_dch   <= r_ch_sel;
                  r_data  <= conv.conv_result;
                  r_go    <= 1'b0;
                  r_state <= S_RELEASE;
               end else if (r_wdog == c_wdw'(TIMEOUT - 1)) begin
                  r_err   <= 1'b1;
                  r_go    <= 1'b0;
                  r_state <= S_RELEASE;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_RELEASE: begin
               // Controller must drop valid before the mux may move on.
               if (!conv.conv_valid) begin
                  if (w_next.found) begin
                     r_ch_sel <= c_cw'(w_next.idx);
                     r_cnt    <= settle;
                     r_state  <= S_SETTLE;
                  end else begin
                     r_sd <= 1'b1;
                     if (continuous && !w_stop_req && w_first.found) begin
                        r_mask   <= ch_en;
                        r_ch_sel <= c_cw'(w_first.idx);
                        r_cnt    <= settle;
                        r_state  <= S_SETTLE;
                     end else begin
                        r_busy  <= 1'b0;
                        r_stop  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   sar_result_bank #(.NCH(NCH), .W(W)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_we),
      .waddr (r_ch_sel),
      .wdata (conv.conv_result),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign conv.ch_sel  = r_ch_sel;
   assign conv.conv_go = r_go;
   assign data_valid   = r_dv;
   assign data_ch      = r_dch;
   assign data         = r_data;
   assign busy         = r_busy;
   assign scan_done    = r_sd;
   assign err          = r_err;
endmodule
`default_nettype wire

// File: tb/tb_sar_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sar_scan_sequencer: scoreboard bench with a simple SAR model       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_sar_scan_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, continuous = 1'b0, stop = 1'b0;
   logic [3:0] ch_en = '0;
   logic [3:0] settle = '0;
   logic [1:0] rd_addr = '0;
   logic [7:0] rd_data, data;
   logic [1:0] data_ch;
   logic       data_valid, busy, scan_done, err;

   sar_scan_sequencer_if #(.NCH(4), .W(8)) ifc ();

   sar_scan_sequencer #(.NCH(4), .W(8), .SETTLE_W(4), .TIMEOUT(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .continuous (continuous),
      .stop       (stop),
      .ch_en      (ch_en),
      .settle     (settle),
      .conv       (ifc),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .data_valid (data_valid),
      .data_ch    (data_ch),
      .data       (data),
      .busy       (busy),
      .scan_done  (scan_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int         n_checks = 0, n_fail = 0;
   int         sd_cnt = 0, cyc = 0, last_chg = 0;
   logic       chk_timing = 1'b0;
   logic [7:0] tab [4];
   logic [3:0] hang_ch = '0;
   logic [1:0] exp_ch [$];
   logic [7:0] exp_d  [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic expect_result(input logic [1:0] ch, input logic [7:0] d);
      exp_ch.push_back(ch);
      exp_d.push_back(d);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int maxc, input string nm);
      int n = 0;
      while (busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk({nm, "_idle_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_go(input int maxc, input string nm);
      int n = 0;
      while (!ifc.conv_go && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.conv_go) chk({nm, "_go_timeout"}, 32'(ifc.conv_go), 32'd1);
   endtask

   task automatic chk_bank(input logic [1:0] a, input logic [7:0] exp, input string nm);
      rd_addr = a;
      #1;
      chk(nm, 32'(rd_data), 32'(exp));
   endtask

   // SAR controller model: valid 3 cycles after go, held until go drops.
   initial begin
      int cnt = 0;
      ifc.conv_valid  = 1'b0;
      ifc.conv_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!ifc.conv_go) begin
            ifc.conv_valid = 1'b0;
            cnt = 0;
         end else if (!hang_ch[ifc.ch_sel] && !ifc.conv_valid) begin
            cnt++;
            if (cnt == 3) begin
               ifc.conv_valid  = 1'b1;
               ifc.conv_result = tab[ifc.ch_sel];
            end
         end
      end
   end

   // Monitor: scoreboard pop on data_valid, scan_done count, go timing.
   initial begin
      logic [1:0] prev_sel = '0;
      logic       prev_busy = 1'b0, prev_go = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (ifc.ch_sel != prev_sel || (busy && !prev_busy)) last_chg = cyc;
         if (chk_timing && ifc.conv_go && !prev_go)
            chk("go_after_sel", 32'(cyc - last_chg), 32'd3);
         if (data_valid) begin
            if (exp_ch.size() == 0) begin
               chk("unexpected_data_valid", {22'd0, data_ch, data}, 32'hffff_ffff);
            end else begin
               chk("data_ch", 32'(data_ch), 32'(exp_ch.pop_front()));
               chk("data", 32'(data), 32'(exp_d.pop_front()));
            end
         end
         if (scan_done) sd_cnt++;
         prev_sel  = ifc.ch_sel;
         prev_busy = busy;
         prev_go   = ifc.conv_go;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int sd0, len;
      tab[0] = 8'h46; tab[1] = 8'h80; tab[2] = 8'h77; tab[3] = 8'h12;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_busy", 32'(busy), 0);
      chk("rst_go", 32'(ifc.conv_go), 0);
      chk("rst_ch_sel", 32'(ifc.ch_sel), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_done", 32'(scan_done), 0);
      chk_bank(2'd0, 8'h00, "rst_bank0");

      // Sparse scan 1011, settle 2
      ch_en = 4'b1011; settle = 4'd2; sd0 = sd_cnt;
      expect_result(2'd0, 8'h46);
      expect_result(2'd1, 8'h80);
      expect_result(2'd3, 8'h12);
      chk_timing = 1'b1;
      pulse_start();
      wait_idle(300, "scan1");
      chk_timing = 1'b0;
      repeat (3) @(negedge clk);
      chk("scan1_done_cnt", 32'(sd_cnt - sd0), 1);
      chk("scan1_q_empty", 32'(exp_ch.size()), 0);
      chk_bank(2'd0, 8'h46, "scan1_bank0");
      chk_bank(2'd1, 8'h80, "scan1_bank1");
      chk_bank(2'd2, 8'h00, "scan1_bank2");
      chk_bank(2'd3, 8'h12, "scan1_bank3");
      chk("scan1_err", 32'(err), 0);

      // Continuous with stop raised mid-conversion
      tab[0] = 8'h5a; ch_en = 4'b0001; settle = 4'd0; continuous = 1'b1; sd0 = sd_cnt;
      expect_result(2'd0, 8'h5a);
      pulse_start();
      wait_go(20, "stop");
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle(100, "stop");
      continuous = 1'b0;
      repeat (3) @(negedge clk);
      chk("stop_done_cnt", 32'(sd_cnt - sd0), 1);
      chk("stop_busy", 32'(busy), 0);
      chk("stop_q_empty", 32'(exp_ch.size()), 0);
      chk_bank(2'd0, 8'h5a, "stop_bank0");

      // Watchdog: ch0 never answers, ch1 does
      hang_ch = 4'b0001; tab[1] = 8'h33; ch_en = 4'b0011; settle = 4'd1;
      expect_result(2'd1, 8'h33);
      pulse_start();
      chk("to_err_cleared", 32'(err), 0);
      wait_go(20, "to");
      len = 0;
      while (ifc.conv_go && len < 100) begin
         @(negedge clk);
         len++;
      end
      chk("to_go_len", 32'(len), 64);
      chk("to_err", 32'(err), 1);
      wait_idle(100, "to");
      repeat (2) @(negedge clk);
      chk("to_err_sticky", 32'(err), 1);
      chk("to_q_empty", 32'(exp_ch.size()), 0);
      chk_bank(2'd0, 8'h5a, "to_bank0_kept");
      chk_bank(2'd1, 8'h33, "to_bank1");
      hang_ch = '0;

      // Empty mask start, then start pulses while busy
      ch_en = 4'b0000; sd0 = sd_cnt;
      pulse_start();
      chk("empty_busy", 32'(busy), 0);
      @(negedge clk);
      chk("empty_done_cnt", 32'(sd_cnt - sd0), 1);
      ch_en = 4'b0100; settle = 4'd3; sd0 = sd_cnt;
      expect_result(2'd2, 8'h77);
      pulse_start();
      @(negedge clk);
      pulse_start();
      repeat (3) @(negedge clk);
      pulse_start();
      wait_idle(100, "ign");
      repeat (4) @(negedge clk);
      chk("ign_done_cnt", 32'(sd_cnt - sd0), 1);
      chk("ign_busy", 32'(busy), 0);
      chk("ign_q_empty", 32'(exp_ch.size()), 0);

      // Reset during conversion
      hang_ch = 4'b0001; ch_en = 4'b0001; settle = 4'd0;
      pulse_start();
      wait_go(20, "rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstc_go", 32'(ifc.conv_go), 0);
      chk("rstc_busy", 32'(busy), 0);
      for (int a = 0; a < 4; a++) chk_bank(2'(a), 8'h00, "rstc_bank");
      repeat (3) @(negedge clk);
      chk("rstc_q_empty", 32'(exp_ch.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
